// File: rtl/axis_video_sink.sv
// AXI4-Stream video sink: buffers RGB beats in a FIFO and replays them against
// locally generated raster timing, relocking on start-of-frame after any error.
module axis_video_sink #(
  parameter int H_FP       = 16,
  parameter int H_VISIBLE  = 640,
  parameter int H_BP       = 48,
  parameter int H_SYNC     = 96,
  parameter int V_FP       = 10,
  parameter int V_VISIBLE  = 480,
  parameter int V_BP       = 33,
  parameter int V_SYNC     = 2,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tuser,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [11:0] rgb_out,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        locked,
  output logic        underflow_err,
  output logic        frame_err
);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [9:0] X_ACT_LO  = 10'(H_FP);
  localparam logic [9:0] X_ACT_HI  = 10'(H_FP + H_VISIBLE - 1);
  localparam logic [9:0] X_SYNC_LO = 10'(H_FP + H_VISIBLE + H_BP);
  localparam logic [9:0] X_MAX     = 10'(H_FP + H_VISIBLE + H_BP + H_SYNC - 1);
  localparam logic [9:0] X_PRE     = 10'(H_FP - 1);
  localparam logic [9:0] Y_ACT_LO  = 10'(V_FP);
  localparam logic [9:0] Y_ACT_HI  = 10'(V_FP + V_VISIBLE - 1);
  localparam logic [9:0] Y_SYNC_LO = 10'(V_FP + V_VISIBLE + V_BP);
  localparam logic [9:0] Y_MAX     = 10'(V_FP + V_VISIBLE + V_BP + V_SYNC - 1);
  localparam logic [9:0] Y_PRE     = 10'(V_FP - 1);

  typedef enum logic [1:0] {SEEK, WAIT_SOF, RUN} state_t;

  state_t        state_q, state_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic [AW:0]   wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [25:0]   mem [FIFO_DEPTH];
  logic [25:0]   wr_word;
  logic [13:0]   head_q;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          fifo_empty, fifo_full, push, pop;
  logic          head_user, head_last;
  logic          active, at_first, at_line_end, pre_first;
  logic          uf_evt, fe_evt, locked_d;
  logic [11:0]   rgb_d;

  logic          hsync_q, vsync_q, video_on_q, locked_q, underflow_q, frame_err_q;
  logic [11:0]   rgb_q;
  logic [9:0]    pixel_x_q, pixel_y_q;

  // Raster counters free-run from reset regardless of lock state.
  always_comb begin
    x_d = x_q + 10'd1;
    y_d = y_q;
    if (x_q == X_MAX) begin
      x_d = 10'd0;
      y_d = (y_q == Y_MAX) ? 10'd0 : y_q + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= 10'd0;
      y_q <= 10'd0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign active      = (x_q >= X_ACT_LO) && (x_q <= X_ACT_HI) &&
                       (y_q >= Y_ACT_LO) && (y_q <= Y_ACT_HI);
  assign at_first    = (x_q == X_ACT_LO) && (y_q == Y_ACT_LO);
  assign at_line_end = (x_q == X_ACT_HI);
  assign pre_first   = (x_q == X_PRE) && (y_q == Y_PRE);

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign s_tready   = !reset && !fifo_full;
  assign push       = s_tvalid && s_tready;
  assign wr_word    = {s_tuser, s_tlast, s_tdata};
  assign rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
  assign wr_idx     = wr_ptr_q[AW-1:0];
  assign rd_idx     = rd_ptr_d[AW-1:0];
  assign head_user  = head_q[13];
  assign head_last  = head_q[12];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= wr_word;
  end

  // Show-ahead head register: prefetches the word at the next read pointer,
  // bypassing the RAM when that slot is being written this cycle.
  always_ff @(posedge clk) begin
    if (push && (wr_idx == rd_idx))
      head_q <= {wr_word[25:20], wr_word[15:12], wr_word[7:4]};
    else
      head_q <= {mem[rd_idx][25:20], mem[rd_idx][15:12], mem[rd_idx][7:4]};
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= SEEK;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEEK:     if (!fifo_empty && head_user) state_d = WAIT_SOF;
      WAIT_SOF: if (pre_first) state_d = RUN;
      RUN: begin
        if (active) begin
          if (fifo_empty)                    state_d = SEEK;
          else if (head_user && !at_first)   state_d = SEEK;
          else if (head_last != at_line_end) state_d = SEEK;
        end
      end
      default:  state_d = SEEK;
    endcase
  end

  // A mispositioned start-of-frame word is left in the FIFO so SEEK relocks on it.
  always_comb begin
    pop    = 1'b0;
    uf_evt = 1'b0;
    fe_evt = 1'b0;
    case (state_q)
      SEEK: pop = !active && !fifo_empty && !head_user;
      RUN: begin
        if (active) begin
          if (fifo_empty) begin
            uf_evt = 1'b1;
          end else if (head_user && !at_first) begin
            fe_evt = 1'b1;
          end else begin
            pop    = 1'b1;
            fe_evt = (head_last != at_line_end);
          end
        end
      end
      default: ;
    endcase
    locked_d = (state_d == RUN);
    rgb_d    = (pop && locked_d) ? head_q[11:0] : 12'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      video_on_q  <= 1'b0;
      rgb_q       <= 12'd0;
      pixel_x_q   <= 10'd0;
      pixel_y_q   <= 10'd0;
      locked_q    <= 1'b0;
      underflow_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      hsync_q     <= (x_q >= X_SYNC_LO);
      vsync_q     <= (y_q >= Y_SYNC_LO);
      video_on_q  <= active;
      rgb_q       <= rgb_d;
      pixel_x_q   <= x_q;
      pixel_y_q   <= y_q;
      locked_q    <= locked_d;
      underflow_q <= underflow_q | uf_evt;
      frame_err_q <= frame_err_q | fe_evt;
    end
  end

  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign video_on      = video_on_q;
  assign rgb_out       = rgb_q;
  assign pixel_x       = pixel_x_q;
  assign pixel_y       = pixel_y_q;
  assign locked        = locked_q;
  assign underflow_err = underflow_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_axis_video_sink.sv
// Directed bench for axis_video_sink on a shrunken 15x9 raster with a 16-deep FIFO.
module tb_axis_video_sink;
  localparam int HF = 2, HV = 8, HB = 2, HS = 3;
  localparam int VF = 2, VV = 4, VB = 1, VS = 2;
  localparam int DEPTH = 16;
  localparam int HT = HF + HV + HB + HS;
  localparam int VT = VF + VV + VB + VS;
  localparam int FT = HT * VT;
  localparam int NPIX = HV * VV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] s_tdata;
  logic        s_tvalid, s_tuser, s_tlast, s_tready;
  logic        hsync, vsync, video_on, locked, underflow_err, frame_err;
  logic [11:0] rgb_out;
  logic [9:0]  pixel_x, pixel_y;

  int          n_checks = 0;
  int          n_errors = 0;
  int          t = 0;
  int          acc = 0;
  bit          prod_en = 1'b0;
  bit          fire = 1'b0;
  logic [25:0] q[$];

  always #5 clk = ~clk;

  axis_video_sink #(
    .H_FP(HF), .H_VISIBLE(HV), .H_BP(HB), .H_SYNC(HS),
    .V_FP(VF), .V_VISIBLE(VV), .V_BP(VB), .V_SYNC(VS),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .s_tready(s_tready),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .rgb_out(rgb_out),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .locked(locked),
    .underflow_err(underflow_err), .frame_err(frame_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at p=%0d: got %0h, expected %0h", tag, t - 1, got, exp);
    end
  endtask

  function automatic logic [11:0] nib(input int kind, input int k);
    int kk;
    kk = k % 16;
    if (kind == 0) return 12'hABC;
    return {4'(kk), (k >= 16), 3'(kind), 4'(15 - kk)};
  endfunction

  function automatic logic [23:0] pix(input int kind, input int k);
    logic [11:0] n;
    if (kind == 0) return 24'hA0B0C0;
    n = nib(kind, k);
    return {n[11:8], 4'h7, n[7:4], 4'h7, n[3:0], 4'h7};
  endfunction

  task automatic enqueue_frame(input int kind, input int nbeats, input int bad_k);
    logic tu, tl;
    for (int k = 0; k < nbeats; k++) begin
      tu = (k == 0);
      tl = ((k % HV) == HV - 1) ^ (k == bad_k);
      q.push_back({tu, tl, pix(kind, k)});
    end
  endtask

  // Producer: presents the queue head; a handshake is judged mid-cycle,
  // once s_tready has settled for the coming rising edge.
  initial begin
    s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0;
    forever begin
      @(negedge clk);
      if (fire && q.size() > 0) begin
        void'(q.pop_front());
        acc++;
      end
      if (prod_en && q.size() > 0) begin
        {s_tuser, s_tlast, s_tdata} = q[0];
        s_tvalid = 1'b1;
      end else begin
        {s_tuser, s_tlast, s_tdata} = '0;
        s_tvalid = 1'b0;
      end
      #2;
      fire = s_tvalid && s_tready;
    end
  end

  task automatic tick();
    int p, x, y;
    @(negedge clk);
    t++;
    p = t - 1;
    x = p % HT;
    y = (p / HT) % VT;
    check_val("pixel_x", 32'(pixel_x), 32'(x));
    check_val("pixel_y", 32'(pixel_y), 32'(y));
    check_val("hsync", 32'(hsync), 32'(x >= HF + HV + HB));
    check_val("vsync", 32'(vsync), 32'(y >= VF + VV + VB));
    check_val("video_on", 32'(video_on), 32'(x >= HF && x < HF + HV && y >= VF && y < VF + VV));
  endtask

  // lock_at: frame offset where locked rises (-1 never); stop_k: active pixel
  // index where lock drops; err: 1 underflow, 2 frame error at stop_k.
  task automatic run_cycles(input int n, input int lock_at, input int kind, input int stop_k,
                            input int err, input bit uf0, input bit fe0);
    int o, x, y, k, stop_o;
    bit act, past, el, eu, ef;
    logic [11:0] er;
    stop_o = (stop_k < NPIX) ? (VF + stop_k / HV) * HT + HF + stop_k % HV : FT + 1;
    for (int i = 0; i < n; i++) begin
      tick();
      o = (t - 1) % FT;
      x = o % HT;
      y = o / HT;
      act = (x >= HF && x < HF + HV && y >= VF && y < VF + VV);
      k = act ? (y - VF) * HV + (x - HF) : 0;
      past = (o >= stop_o);
      el = (lock_at >= 0) && (o >= lock_at) && !past;
      er = (el && act) ? nib(kind, k) : 12'd0;
      eu = uf0 || (err == 1 && past);
      ef = fe0 || (err == 2 && past);
      check_val("locked", 32'(locked), 32'(el));
      check_val("rgb_out", 32'(rgb_out), 32'(er));
      check_val("underflow_err", 32'(underflow_err), 32'(eu));
      check_val("frame_err", 32'(frame_err), 32'(ef));
    end
  endtask

  task automatic check_reset_state();
    check_val("rst_tready", 32'(s_tready), 32'd0);
    check_val("rst_hsync", 32'(hsync), 32'd0);
    check_val("rst_vsync", 32'(vsync), 32'd0);
    check_val("rst_video_on", 32'(video_on), 32'd0);
    check_val("rst_rgb", 32'(rgb_out), 32'd0);
    check_val("rst_pixel_x", 32'(pixel_x), 32'd0);
    check_val("rst_pixel_y", 32'(pixel_y), 32'd0);
    check_val("rst_locked", 32'(locked), 32'd0);
    check_val("rst_underflow", 32'(underflow_err), 32'd0);
    check_val("rst_frame_err", 32'(frame_err), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_state();
    reset = 1'b0;
    t = 0;

    // Idle frame: raster only, nothing displayed.
    run_cycles(FT, -1, 0, NPIX, 0, 1'b0, 1'b0);
    check_val("tready_idle", 32'(s_tready), 32'd1);

    // Two clean frames, then a frame that runs dry after 20 beats.
    enqueue_frame(0, NPIX, -1);
    enqueue_frame(1, NPIX, -1);
    enqueue_frame(2, 20, -1);
    prod_en = 1'b1;
    run_cycles(FT, 16, 0, NPIX, 0, 1'b0, 1'b0);
    run_cycles(FT, 0, 1, NPIX, 0, 1'b0, 1'b0);
    run_cycles(100, 0, 2, 20, 1, 1'b0, 1'b0);

    // Garbage before SOF, a good frame, an early-tlast frame, a good frame.
    for (int g = 0; g < 5; g++) q.push_back({2'b00, 24'hFFFFFF});
    enqueue_frame(3, NPIX, -1);
    enqueue_frame(7, NPIX, 3);
    enqueue_frame(4, NPIX, -1);
    run_cycles(FT - 100, 0, 2, 20, 1, 1'b0, 1'b0);
    run_cycles(FT, 16, 3, NPIX, 0, 1'b1, 1'b0);
    run_cycles(FT, 0, 7, 3, 2, 1'b1, 1'b0);
    run_cycles(FT, 16, 4, NPIX, 0, 1'b1, 1'b1);
    run_cycles(41, 0, 0, 0, 1, 1'b1, 1'b1);

    // Backpressure: a locked-on burst larger than the FIFO, then reset mid-frame.
    acc = 0;
    enqueue_frame(5, 20, -1);
    run_cycles(60, -1, 0, NPIX, 0, 1'b1, 1'b1);
    check_val("tready_full", 32'(s_tready), 32'd0);
    check_val("beats_accepted", 32'(acc), 32'd16);
    check_val("beats_pending", 32'(q.size()), 32'd4);

    reset = 1'b1;
    prod_en = 1'b0;
    q.delete();
    @(negedge clk);
    check_reset_state();
    @(negedge clk);
    check_reset_state();
    reset = 1'b0;
    t = 0;
    enqueue_frame(6, NPIX, -1);
    prod_en = 1'b1;
    run_cycles(FT, 16, 6, NPIX, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
